// File: rtl/sys_bus_pkg.sv
// Shared helpers for the system bus: index-width sizing for host/device selectors.
package sys_bus_pkg;

  // Selector width for n ports; never narrower than one bit so registers stay legal.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/sys_bus_decoder.sv
// Address decoder: base/mask match against every device, lowest matching index wins.
module sys_bus_decoder
  import sys_bus_pkg::*;
#(
  parameter int NrDevices    = 1,
  parameter int AddressWidth = 32,
  localparam int DevIdxW     = idx_width(NrDevices)
) (
  input  logic [AddressWidth-1:0] addr,
  input  logic [AddressWidth-1:0] cfg_device_addr_base [NrDevices],
  input  logic [AddressWidth-1:0] cfg_device_addr_mask [NrDevices],
  output logic                    hit,
  output logic [DevIdxW-1:0]      dev_idx
);

  logic [NrDevices-1:0] match;

  for (genvar gi = 0; gi < NrDevices; gi++) begin : g_match
    assign match[gi] = (addr & cfg_device_addr_mask[gi]) ==
                       (cfg_device_addr_base[gi] & cfg_device_addr_mask[gi]);
  end

  // Scan downwards so the last assignment, the lowest index, takes precedence.
  always_comb begin
    hit     = 1'b0;
    dev_idx = '0;
    for (int d = NrDevices - 1; d >= 0; d--) begin
      if (match[d]) begin
        hit     = 1'b1;
        dev_idx = DevIdxW'(d);
      end
    end
  end

endmodule

// File: rtl/sys_bus.sv
// Single-layer interconnect: fixed-priority host arbitration, address decode to devices,
// and one-cycle-later routing of the device response back to the granted host.
module sys_bus
  import sys_bus_pkg::*;
#(
  parameter int NrDevices    = 1,
  parameter int NrHosts      = 1,
  parameter int DataWidth    = 32,
  parameter int AddressWidth = 32
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  input  logic [NrHosts-1:0]        host_req_i,
  output logic [NrHosts-1:0]        host_gnt_o,
  input  logic [AddressWidth-1:0]   host_addr_i  [NrHosts],
  input  logic [NrHosts-1:0]        host_we_i,
  input  logic [DataWidth/8-1:0]    host_be_i    [NrHosts],
  input  logic [DataWidth-1:0]      host_wdata_i [NrHosts],
  output logic [NrHosts-1:0]        host_rvalid_o,
  output logic [DataWidth-1:0]      host_rdata_o [NrHosts],
  output logic [NrHosts-1:0]        host_err_o,
  output logic [NrDevices-1:0]      device_req_o,
  output logic [AddressWidth-1:0]   device_addr_o  [NrDevices],
  output logic [NrDevices-1:0]      device_we_o,
  output logic [DataWidth/8-1:0]    device_be_o    [NrDevices],
  output logic [DataWidth-1:0]      device_wdata_o [NrDevices],
  input  logic [NrDevices-1:0]      device_rvalid_i,
  input  logic [DataWidth-1:0]      device_rdata_i [NrDevices],
  input  logic [NrDevices-1:0]      device_err_i,
  input  logic [AddressWidth-1:0]   cfg_device_addr_base [NrDevices],
  input  logic [AddressWidth-1:0]   cfg_device_addr_mask [NrDevices]
);

  localparam int HostIdxW = idx_width(NrHosts);
  localparam int DevIdxW  = idx_width(NrDevices);

  logic                    any_req;
  logic [HostIdxW-1:0]     host_sel_next;
  logic [AddressWidth-1:0] win_addr;
  logic                    win_we;
  logic [DataWidth/8-1:0]  win_be;
  logic [DataWidth-1:0]    win_wdata;
  logic                    dev_hit;
  logic [DevIdxW-1:0]      dev_idx;

  logic                    pending_reg;
  logic                    unmapped_reg;
  logic [HostIdxW-1:0]     host_sel_reg;
  logic [DevIdxW-1:0]      dev_sel_reg;

  logic                    rsp_valid;
  logic                    rsp_err;
  logic [DataWidth-1:0]    rsp_data;

  // Fixed priority: scanning downwards leaves the lowest requesting host selected.
  always_comb begin
    any_req       = 1'b0;
    host_sel_next = '0;
    win_addr      = '0;
    win_we        = 1'b0;
    win_be        = '0;
    win_wdata     = '0;
    for (int h = NrHosts - 1; h >= 0; h--) begin
      if (host_req_i[h]) begin
        any_req       = 1'b1;
        host_sel_next = HostIdxW'(h);
        win_addr      = host_addr_i[h];
        win_we        = host_we_i[h];
        win_be        = host_be_i[h];
        win_wdata     = host_wdata_i[h];
      end
    end
  end

  sys_bus_decoder #(
    .NrDevices   (NrDevices),
    .AddressWidth(AddressWidth)
  ) u_decoder (
    .addr                (win_addr),
    .cfg_device_addr_base(cfg_device_addr_base),
    .cfg_device_addr_mask(cfg_device_addr_mask),
    .hit                 (dev_hit),
    .dev_idx             (dev_idx)
  );

  for (genvar gi = 0; gi < NrHosts; gi++) begin : g_gnt
    assign host_gnt_o[gi] = any_req && (host_sel_next == HostIdxW'(gi));
  end

  for (genvar gi = 0; gi < NrDevices; gi++) begin : g_dev
    assign device_req_o[gi]   = any_req && dev_hit && (dev_idx == DevIdxW'(gi));
    assign device_addr_o[gi]  = win_addr;
    assign device_we_o[gi]    = win_we;
    assign device_be_o[gi]    = win_be;
    assign device_wdata_o[gi] = win_wdata;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      pending_reg  <= 1'b0;
      unmapped_reg <= 1'b0;
      host_sel_reg <= '0;
      dev_sel_reg  <= '0;
    end else begin
      pending_reg  <= any_req;
      unmapped_reg <= ~dev_hit;
      host_sel_reg <= host_sel_next;
      dev_sel_reg  <= dev_idx;
    end
  end

  // Unmapped accesses get a synthetic error response instead of the device's.
  always_comb begin
    rsp_valid = 1'b0;
    rsp_err   = 1'b0;
    rsp_data  = '0;
    for (int d = 0; d < NrDevices; d++) begin
      if (dev_sel_reg == DevIdxW'(d)) begin
        rsp_valid = device_rvalid_i[d];
        rsp_err   = device_err_i[d];
        rsp_data  = device_rdata_i[d];
      end
    end
    if (unmapped_reg) begin
      rsp_valid = 1'b1;
      rsp_err   = 1'b1;
      rsp_data  = '0;
    end
  end

  for (genvar gi = 0; gi < NrHosts; gi++) begin : g_rsp
    logic sel;
    assign sel               = pending_reg && (host_sel_reg == HostIdxW'(gi));
    assign host_rvalid_o[gi] = sel && rsp_valid;
    assign host_err_o[gi]    = sel && rsp_err;
    assign host_rdata_o[gi]  = sel ? rsp_data : '0;
  end

endmodule

// File: tb/tb_sys_bus.sv
// Directed bench for sys_bus: two hosts, RAM / SimCtrl / Timer devices answering one cycle after req.
module tb_sys_bus;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [1:0]  host_req = '0;
  logic [1:0]  host_gnt;
  logic [31:0] host_addr [2];
  logic [1:0]  host_we = '0;
  logic [3:0]  host_be [2];
  logic [31:0] host_wdata [2];
  logic [1:0]  host_rvalid;
  logic [31:0] host_rdata [2];
  logic [1:0]  host_err;
  logic [2:0]  device_req;
  logic [31:0] device_addr [3];
  logic [2:0]  device_we;
  logic [3:0]  device_be [3];
  logic [31:0] device_wdata [3];
  logic [2:0]  device_rvalid = '0;
  logic [31:0] device_rdata [3];
  logic [2:0]  device_err = '0;
  logic [31:0] cfg_base [3];
  logic [31:0] cfg_mask [3];

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  sys_bus #(
    .NrDevices(3), .NrHosts(2), .DataWidth(32), .AddressWidth(32)
  ) dut (
    .clk_i(clk), .rst_i(rst),
    .host_req_i(host_req), .host_gnt_o(host_gnt), .host_addr_i(host_addr),
    .host_we_i(host_we), .host_be_i(host_be), .host_wdata_i(host_wdata),
    .host_rvalid_o(host_rvalid), .host_rdata_o(host_rdata), .host_err_o(host_err),
    .device_req_o(device_req), .device_addr_o(device_addr), .device_we_o(device_we),
    .device_be_o(device_be), .device_wdata_o(device_wdata),
    .device_rvalid_i(device_rvalid), .device_rdata_i(device_rdata), .device_err_i(device_err),
    .cfg_device_addr_base(cfg_base), .cfg_device_addr_mask(cfg_mask)
  );

  // Device model: answer one cycle after req; rdata = 0xD0 | dev<<24 | addr[15:0]; Timer always errors.
  always @(posedge clk) begin
    device_rvalid <= device_req;
    device_err    <= {device_req[2], 2'b00};
    for (int d = 0; d < 3; d++)
      device_rdata[d] <= 32'hD000_0000 | (32'(d) << 24) | {16'h0, device_addr[d][15:0]};
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
    $display("check %s observed=%h expected=%h", tag, obs, exp);
  endtask

  task automatic issue(input int h, input logic [31:0] a, input logic we, input logic [31:0] wd);
    host_addr[h]  = a;
    host_we[h]    = we;
    host_be[h]    = 4'hF;
    host_wdata[h] = wd;
    host_req[h]   = 1'b1;
  endtask

  initial begin
    cfg_base[0] = 32'h0010_0000; cfg_mask[0] = ~32'h000F_FFFF;
    cfg_base[1] = 32'h0002_0000; cfg_mask[1] = ~32'h0000_03FF;
    cfg_base[2] = 32'h0003_0000; cfg_mask[2] = ~32'h0000_03FF;
    for (int h = 0; h < 2; h++) begin
      host_addr[h] = '0; host_be[h] = '0; host_wdata[h] = '0;
    end

    // Reset state
    repeat (2) @(negedge clk);
    chk("rst_rvalid", 32'(host_rvalid), 32'h0);
    chk("rst_err", 32'(host_err), 32'h0);
    chk("rst_rdata0", host_rdata[0], 32'h0);
    rst = 1'b0;

    // RAM read
    @(negedge clk);
    issue(0, 32'h0010_0010, 1'b0, 32'h0);
    #1;
    chk("rd_gnt", 32'(host_gnt), 32'h1);
    chk("rd_dreq", 32'(device_req), 32'h1);
    chk("rd_daddr", device_addr[0], 32'h0010_0010);
    @(posedge clk); #1;
    host_req = '0;
    chk("rd_rvalid", 32'(host_rvalid), 32'h1);
    chk("rd_rdata", host_rdata[0], 32'hD000_0010);
    chk("rd_err", 32'(host_err), 32'h0);

    // SimCtrl write
    @(negedge clk);
    issue(0, 32'h0002_0008, 1'b1, 32'h41);
    #1;
    chk("wr_dreq", 32'(device_req), 32'h2);
    chk("wr_daddr", device_addr[1], 32'h0002_0008);
    chk("wr_dwe", 32'(device_we[1]), 32'h1);
    chk("wr_dbe", 32'(device_be[1]), 32'hF);
    chk("wr_dwdata", device_wdata[1], 32'h41);
    @(posedge clk); #1;
    host_req = '0;
    chk("wr_rvalid", 32'(host_rvalid), 32'h1);
    chk("wr_err", 32'(host_err), 32'h0);

    // Unmapped access
    @(negedge clk);
    issue(0, 32'h0004_0000, 1'b0, 32'h0);
    #1;
    chk("um_gnt", 32'(host_gnt), 32'h1);
    chk("um_dreq", 32'(device_req), 32'h0);
    @(posedge clk); #1;
    host_req = '0;
    chk("um_rvalid", 32'(host_rvalid), 32'h1);
    chk("um_err", 32'(host_err), 32'h1);
    chk("um_rdata", host_rdata[0], 32'h0);

    // Timer error response
    @(negedge clk);
    issue(0, 32'h0003_0004, 1'b0, 32'h0);
    #1;
    chk("tm_dreq", 32'(device_req), 32'h4);
    @(posedge clk); #1;
    host_req = '0;
    chk("tm_rvalid", 32'(host_rvalid), 32'h1);
    chk("tm_err", 32'(host_err), 32'h1);
    chk("tm_rdata", host_rdata[0], 32'hD200_0004);

    // Two hosts contend; host 1 follows back-to-back
    @(negedge clk);
    issue(0, 32'h0010_0020, 1'b0, 32'h0);
    issue(1, 32'h0002_0010, 1'b0, 32'h0);
    #1;
    chk("arb_gnt", 32'(host_gnt), 32'h1);
    chk("arb_dreq", 32'(device_req), 32'h1);
    @(posedge clk); #1;
    host_req[0] = 1'b0;
    #1;
    chk("arb_rvalid_h0", 32'(host_rvalid), 32'h1);
    chk("arb_rdata_h0", host_rdata[0], 32'hD000_0020);
    chk("arb_rdata_h1_idle", host_rdata[1], 32'h0);
    chk("arb_gnt_h1", 32'(host_gnt), 32'h2);
    chk("arb_dreq_h1", 32'(device_req), 32'h2);
    @(posedge clk); #1;
    host_req = '0;
    chk("arb_rvalid_h1", 32'(host_rvalid), 32'h2);
    chk("arb_rdata_h1", host_rdata[1], 32'hD100_0010);
    chk("arb_rdata_h0_idle", host_rdata[0], 32'h0);
    chk("arb_err_h1", 32'(host_err), 32'h0);

    // Reset while a response is due
    @(negedge clk);
    issue(0, 32'h0010_0000, 1'b0, 32'h0);
    @(posedge clk); #1;
    host_req = '0;
    rst = 1'b1;
    #1;
    chk("rst_mid_rvalid", 32'(host_rvalid), 32'h0);
    chk("rst_mid_err", 32'(host_err), 32'h0);
    chk("rst_mid_rdata", host_rdata[0], 32'h0);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk); #1;
    chk("rst_after_rvalid", 32'(host_rvalid), 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
